fact_engine: RTL and testbench

- Parametrised, self-contained iterative factorial unit; successor to the core's fixed 16-bit, ALU-coupled factorial helper.
- Computes n! with its own shift-add multiplier, so the core ALU is not occupied during FACT.
- Adds a start/busy/done handshake, configurable operand and result widths, and a sticky overflow flag.
- Sits beside the ALU; the CU stalls the PC on busy and writes result to ACC on done.

---
 rtl/gpp_calc_pkg.sv | 14 +
 rtl/fact_engine_if.sv | 20 ++
 rtl/fact_shift_add_mul.sv | 49 ++++
 rtl/fact_engine.sv | 119 +++++++++++
 tb/tb_fact_engine.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/gpp_calc_pkg.sv
// Shared definitions for the factorial engine slice: FSM state encoding and
// default operand/result widths.
package gpp_calc_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int N_W_DEF    = 9;

   typedef enum logic [1:0] {
      FE_IDLE = 2'd0,
      FE_MUL  = 2'd1,
      FE_DONE = 2'd2
   } fe_state_e;

endpackage

// File: rtl/fact_engine_if.sv
// Start/busy/done handshake bundle between the control unit (master) and the
// factorial engine (slave).
interface fact_engine_if
   import gpp_calc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF
);

   logic              start;
   logic [N_W-1:0]    n;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;
   logic              ovf;

   modport master (output start, n, input busy, done, result, ovf);
   modport slave  (input start, n, output busy, done, result, ovf);

endinterface

// File: rtl/fact_shift_add_mul.sv
// Serial shift-add multiplier: one multiplier bit per step, LSB first,
// DATA_W x N_W -> DATA_W+N_W. 'product' is the running sum including the current bit.
module fact_shift_add_mul
   import gpp_calc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    step,
   input  logic [DATA_W-1:0]       a,
   input  logic [N_W-1:0]          b,
   output logic [DATA_W+N_W-1:0]   product,
   output logic                    last
);

   localparam int P_W   = DATA_W + N_W;
   localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

   logic [P_W-1:0]   partial;
   logic [P_W-1:0]   addend;
   logic [CNT_W-1:0] bitcnt;

   always_comb begin
      addend = '0;
      if (b[bitcnt]) begin
         addend = {{N_W{1'b0}}, a} << bitcnt;
      end
      product = partial + addend;
      last    = (bitcnt == CNT_W'(N_W - 1));
   end

   // The final step hands its product to the engine and clears itself for the next iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         partial <= '0;
         bitcnt  <= '0;
      end else if (load || (step && last)) begin
         partial <= '0;
         bitcnt  <= '0;
      end else if (step) begin
         partial <= product;
         bitcnt  <= bitcnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fact_engine.sv
// Iterative factorial unit with its own serial multiplier and sticky overflow.
// Optional macro FACT_ENGINE_OVF_ABORT_EN: saturate and finish on the first overflowing iteration.
module fact_engine
   import gpp_calc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   fact_engine_if.slave  bus
);

   localparam int P_W = DATA_W + N_W;

   fe_state_e         state;
   fe_state_e         next_state;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] result_q;
   logic [N_W-1:0]    i_cnt;
   logic              ovf_run;
   logic              ovf_q;
   logic [P_W-1:0]    product;
   logic              accept;
   logic              mul_step;
   logic              mul_last;
   logic              iter_end;
   logic              iter_ovf;
   logic              abort;
   logic              finish;

   assign accept   = (state == FE_IDLE) && bus.start;
   assign mul_step = (state == FE_MUL);
   assign iter_end = mul_step && mul_last;
   assign iter_ovf = |product[P_W-1:DATA_W];

`ifdef FACT_ENGINE_OVF_ABORT_EN
   assign abort = iter_end && iter_ovf;
`else
   assign abort = 1'b0;
`endif

   // i is decremented at the end of each iteration, so i<=2 now means i<2 afterwards.
   assign finish = iter_end && ((i_cnt <= N_W'(2)) || abort);

   fact_shift_add_mul #(
      .DATA_W (DATA_W),
      .N_W    (N_W)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (mul_step),
      .a       (acc),
      .b       (i_cnt),
      .product (product),
      .last    (mul_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FE_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         FE_IDLE: if (bus.start) next_state = (bus.n < N_W'(2)) ? FE_DONE : FE_MUL;
         FE_MUL:  if (finish)    next_state = FE_DONE;
         FE_DONE: next_state = FE_IDLE;
         default: next_state = FE_IDLE;
      endcase
   end

   // Held copies of result/ovf keep the last answer visible while the next operation runs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         i_cnt    <= '0;
         ovf_run  <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) begin
            acc     <= DATA_W'(1);
            i_cnt   <= bus.n;
            ovf_run <= 1'b0;
         end else if (iter_end) begin
            acc     <= abort ? '1 : product[DATA_W-1:0];
            ovf_run <= ovf_run | iter_ovf;
            i_cnt   <= i_cnt - N_W'(1);
         end
         if (state == FE_DONE) begin
            result_q <= acc;
            ovf_q    <= ovf_run;
         end
      end
   end

   always_comb begin
      bus.busy   = 1'b0;
      bus.done   = 1'b0;
      bus.result = result_q;
      bus.ovf    = ovf_q;
      case (state)
         FE_MUL:  bus.busy = 1'b1;
         FE_DONE: begin
            bus.done   = 1'b1;
            bus.result = acc;
            bus.ovf    = ovf_run;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fact_engine.sv
// Self-checking bench for fact_engine: a N_W=4 instance and a default-width instance,
// directed and random operands checked against a plain-arithmetic factorial model.
module tb_fact_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       tb_start;
   logic [8:0] tb_n;
   logic       sel;

   int checks_total  = 0;
   int checks_passed = 0;

   fact_engine_if #(.DATA_W(16), .N_W(4)) a_if ();
   fact_engine_if #(.DATA_W(16), .N_W(9)) b_if ();

   fact_engine #(.DATA_W(16), .N_W(4)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   fact_engine #(.DATA_W(16), .N_W(9)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

   assign a_if.start = tb_start && !sel;
   assign a_if.n     = tb_n[3:0];
   assign b_if.start = tb_start && sel;
   assign b_if.n     = tb_n;

   logic        o_busy, o_done, o_ovf;
   logic [15:0] o_result;
   assign o_busy   = sel ? b_if.busy   : a_if.busy;
   assign o_done   = sel ? b_if.done   : a_if.done;
   assign o_ovf    = sel ? b_if.ovf    : a_if.ovf;
   assign o_result = sel ? b_if.result : a_if.result;

   always #5 clk = ~clk;

   // Factorial by repeated multiplication, wrapping at 16 bits each step.
   function automatic void ref_model(input int nv, input int nw, output logic [63:0] res,
                                     output logic ovf, output int lat);
      longint acc = 1;
      longint prod;
      ovf = 1'b0;
      lat = 0;
      for (int k = nv; k >= 2; k--) begin
         prod = acc * k;
         lat += nw;
         if (prod >= 65536) begin
            ovf = 1'b1;
`ifdef FACT_ENGINE_OVF_ABORT_EN
            acc = 65535;
            break;
`endif
         end
         acc = prod % 65536;
      end
      res = 64'(acc);
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic apply_stimulus(input int nv, input bit pulses);
      logic [63:0] exp_res;
      logic        exp_ovf;
      int          exp_lat;
      int          lat;
      int          busy_cycles;
      bit          stable;
      logic [15:0] held_res;
      logic        held_ovf;
      ref_model(nv, sel ? 9 : 4, exp_res, exp_ovf, exp_lat);
      @(negedge clk);
      tb_n     = 9'(nv);
      tb_start = 1'b1;
      held_res = o_result;
      held_ovf = o_ovf;
      @(posedge clk);
      lat         = -1;
      busy_cycles = 0;
      stable      = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (o_done) begin
            lat = k;
            break;
         end
         if (o_busy) busy_cycles++;
         if (o_result !== held_res || o_ovf !== held_ovf) stable = 1'b0;
         tb_start = pulses && (k < 3);
      end
      tb_start = 1'b0;
      check_output($sformatf("latency n=%0d", nv), 64'(lat), 64'(exp_lat));
      check_output($sformatf("result n=%0d", nv), 64'(o_result), exp_res);
      check_output($sformatf("ovf n=%0d", nv), 64'(o_ovf), 64'(exp_ovf));
      check_output($sformatf("busy_cycles n=%0d", nv), 64'(busy_cycles), 64'(exp_lat));
      check_output($sformatf("held_while_busy n=%0d", nv), 64'(stable), 64'd1);
      @(negedge clk);
      check_output($sformatf("idle_after n=%0d", nv), 64'({o_busy, o_done}), 64'd0);
   endtask

   initial begin
      logic [63:0] exp_res;
      logic        exp_ovf;
      int          exp_lat;
      int          done_at [3];
      int          cnt;
      bit          prev_done;

      rst      = 1'b1;
      tb_start = 1'b0;
      tb_n     = '0;
      sel      = 1'b0;
      repeat (2) @(negedge clk);
      check_output("reset busy", 64'(a_if.busy), 64'd0);
      check_output("reset done", 64'(a_if.done), 64'd0);
      check_output("reset result", 64'(a_if.result), 64'd0);
      check_output("reset ovf", 64'(a_if.ovf), 64'd0);
      check_output("reset result_b", 64'(b_if.result), 64'd0);
      rst = 1'b0;

      apply_stimulus(3, 1'b0);

      // Reset in the middle of a multiplication
      @(negedge clk);
      tb_n     = 9'd7;
      tb_start = 1'b1;
      @(negedge clk);
      tb_start = 1'b0;
      repeat (5) @(negedge clk);
      check_output("busy before reset", 64'(o_busy), 64'd1);
      rst = 1'b1;
      #1;
      check_output("midop reset busy", 64'(o_busy), 64'd0);
      check_output("midop reset done", 64'(o_done), 64'd0);
      check_output("midop reset result", 64'(o_result), 64'd0);
      check_output("midop reset ovf", 64'(o_ovf), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(3, 1'b0);

      apply_stimulus(0, 1'b0);
      apply_stimulus(1, 1'b0);
      apply_stimulus(5, 1'b0);
      apply_stimulus(8, 1'b0);
      apply_stimulus(9, 1'b0);
      apply_stimulus(4, 1'b1);

      // Start held high: back-to-back operations with one IDLE cycle between them
      ref_model(3, 4, exp_res, exp_ovf, exp_lat);
      done_at   = '{0, 0, 0};
      cnt       = 0;
      prev_done = 1'b0;
      @(negedge clk);
      tb_n     = 9'd3;
      tb_start = 1'b1;
      for (int k = 0; k < 200 && cnt < 3; k++) begin
         @(negedge clk);
         if (prev_done) check_output("hold idle_gap", 64'({o_busy, o_done}), 64'd0);
         prev_done = o_done;
         if (o_done) begin
            check_output("hold result", 64'(o_result), exp_res);
            done_at[cnt] = k;
            cnt++;
         end
      end
      tb_start = 1'b0;
      check_output("hold done count", 64'(cnt), 64'd3);
      check_output("hold gap 1", 64'(done_at[1] - done_at[0]), 64'(exp_lat + 2));
      check_output("hold gap 2", 64'(done_at[2] - done_at[1]), 64'(exp_lat + 2));
      @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         apply_stimulus(int'($urandom_range(0, 15)), 1'b0);
      end

      @(negedge clk);
      sel = 1'b1;
      apply_stimulus(6, 1'b0);
      for (int r = 0; r < 5; r++) begin
         apply_stimulus(int'($urandom_range(0, 12)), 1'b0);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
